// File: rtl/fpu_mds_pkg.sv
// ============================================================================
// fpu_mds_pkg : shared op codes, states and flag layout for the MDS issuer
// Rev 1.0
// ============================================================================
`default_nettype none

package fpu_mds_pkg;

    localparam logic [1:0] MDS_MUL  = 2'b00;
    localparam logic [1:0] MDS_DIV  = 2'b01;
    localparam logic [1:0] MDS_SQRT = 2'b10;
    localparam logic [1:0] MDS_ILL  = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } mds_state_e;

    localparam logic [31:0] CANON_NAN = 32'h7FC0_0000;

    localparam int NV = 4;
    localparam int DZ = 3;
    localparam int OF = 2;
    localparam int UF = 1;
    localparam int NX = 0;

    localparam logic [4:0] FFLAGS_INVALID = 5'b10000;

    typedef struct packed {
        logic        sign;
        logic [7:0]  exp;
        logic [23:0] sig;
        logic        is_zero;
        logic        is_inf;
        logic        is_nan;
    } operand_t;

endpackage

`default_nettype wire

// File: rtl/fpu_operand_classify.sv
// ============================================================================
// fpu_operand_classify : unpacks one IEEE-754 single and classifies it
// Rev 1.0
// ============================================================================
`default_nettype none

module fpu_operand_classify
    import fpu_mds_pkg::*;
(
    input  logic [31:0] operand,
    output logic        sign,
    output logic [7:0]  exp,
    output logic [23:0] sig,
    output logic        is_zero,
    output logic        is_inf,
    output logic        is_nan,
    output logic        is_snan,
    output logic        is_subnormal
);

    logic [22:0] man;
    logic        exp_zero;
    logic        exp_ones;
    logic        man_zero;

    assign sign     = operand[31];
    assign exp      = operand[30:23];
    assign man      = operand[22:0];
    assign exp_zero = (exp == 8'h00);
    assign exp_ones = (exp == 8'hFF);
    assign man_zero = (man == 23'd0);

    assign sig          = {~exp_zero, man};
    assign is_zero      = exp_zero & man_zero;
    assign is_inf       = exp_ones & man_zero;
    assign is_nan       = exp_ones & ~man_zero;
    // Quiet bit clear marks a signaling NaN.
    assign is_snan      = is_nan & ~man[22];
    assign is_subnormal = exp_zero & ~man_zero;

endmodule

`default_nettype wire

// File: rtl/fpu_mds_issuer.sv
// ============================================================================
// fpu_mds_issuer : start/done initiator for FMUL/FDIV/FSQRT with tagged reply
// Optional watchdog in WAIT enabled by FPU_MDS_WATCHDOG_EN.   Rev 1.0
// ============================================================================
`default_nettype none

module fpu_mds_issuer
    import fpu_mds_pkg::*;
#(
    parameter int TAG_W          = 5,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       req_op,
    input  logic [2:0]       req_rm,
    input  logic [31:0]      req_a,
    input  logic [31:0]      req_b,
    input  logic [TAG_W-1:0] req_tag,
    output logic             mds_start,
    output logic [1:0]       mds_op,
    output logic [2:0]       mds_rm,
    output logic             sign_a,
    output logic             sign_b,
    output logic [7:0]       exp_a,
    output logic [7:0]       exp_b,
    output logic [23:0]      sig_a,
    output logic [23:0]      sig_b,
    output logic             is_zero_a,
    output logic             is_zero_b,
    output logic             is_inf_a,
    output logic             is_inf_b,
    output logic             is_nan_a,
    output logic             is_nan_b,
    output logic             is_signaling,
    output logic             subnormal_sqrt,
    input  logic             mds_done,
    input  logic [31:0]      mds_out,
    input  logic             mds_of,
    input  logic             mds_uf,
    input  logic             mds_nv,
    input  logic             mds_nx,
    input  logic             mds_dz,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [31:0]      rsp_result,
    output logic [TAG_W-1:0] rsp_tag,
    output logic [4:0]       rsp_fflags,
    output logic [4:0]       fflags_acc,
    input  logic             fflags_clr
);

    mds_state_e       state_q, state_d;
    logic [1:0]       op_q, op_d;
    logic [2:0]       rm_q, rm_d;
    operand_t         opa_q, opa_d, opb_q, opb_d;
    logic             signaling_q, signaling_d;
    logic             subsqrt_q, subsqrt_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic [31:0]      result_q, result_d;
    logic [4:0]       fflags_q, fflags_d;
    logic [4:0]       acc_q, acc_d;

    operand_t         cls_a, cls_b;
    logic             a_snan, b_snan, a_subnormal, b_subnormal_unused;
    logic             req_is_sqrt;
    logic [4:0]       unit_flags;

    fpu_operand_classify u_cls_a (
        .operand      (req_a),
        .sign         (cls_a.sign),
        .exp          (cls_a.exp),
        .sig          (cls_a.sig),
        .is_zero      (cls_a.is_zero),
        .is_inf       (cls_a.is_inf),
        .is_nan       (cls_a.is_nan),
        .is_snan      (a_snan),
        .is_subnormal (a_subnormal)
    );

    fpu_operand_classify u_cls_b (
        .operand      (req_b),
        .sign         (cls_b.sign),
        .exp          (cls_b.exp),
        .sig          (cls_b.sig),
        .is_zero      (cls_b.is_zero),
        .is_inf       (cls_b.is_inf),
        .is_nan       (cls_b.is_nan),
        .is_snan      (b_snan),
        .is_subnormal (b_subnormal_unused)
    );

    assign req_is_sqrt = (req_op == MDS_SQRT);

    always_comb begin
        unit_flags     = 5'd0;
        unit_flags[NV] = mds_nv;
        unit_flags[DZ] = mds_dz;
        unit_flags[OF] = mds_of;
        unit_flags[UF] = mds_uf;
        unit_flags[NX] = mds_nx;
    end

`ifdef FPU_MDS_WATCHDOG_EN
    localparam logic [7:0] WD_LIMIT = 8'(TIMEOUT_CYCLES - 1);
    logic [7:0] wd_q, wd_d;
`else
    logic [7:0] timeout_unused;
    assign timeout_unused = 8'(TIMEOUT_CYCLES);
`endif

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        rm_d        = rm_q;
        opa_d       = opa_q;
        opb_d       = opb_q;
        signaling_d = signaling_q;
        subsqrt_d   = subsqrt_q;
        tag_d       = tag_q;
        result_d    = result_q;
        fflags_d    = fflags_q;
`ifdef FPU_MDS_WATCHDOG_EN
        wd_d        = wd_q;
`endif

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    tag_d = req_tag;
                    if (req_op == MDS_ILL) begin
                        result_d = CANON_NAN;
                        fflags_d = FFLAGS_INVALID;
                        state_d  = RESP;
                    end else begin
                        op_d        = req_op;
                        rm_d        = req_rm;
                        opa_d       = cls_a;
                        // B is meaningless for a square root, so present it as all zeros.
                        opb_d       = req_is_sqrt ? '0 : cls_b;
                        signaling_d = a_snan | (b_snan & ~req_is_sqrt);
                        subsqrt_d   = req_is_sqrt & a_subnormal;
                        state_d     = START;
                    end
                end
            end
            START: begin
`ifdef FPU_MDS_WATCHDOG_EN
                wd_d = 8'd0;
`endif
                // Fast-path units may finish in the start cycle itself.
                if (mds_done) begin
                    result_d = mds_out;
                    fflags_d = unit_flags;
                    state_d  = RESP;
                end else begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (mds_done) begin
                    result_d = mds_out;
                    fflags_d = unit_flags;
                    state_d  = RESP;
                end
`ifdef FPU_MDS_WATCHDOG_EN
                else if (wd_q == WD_LIMIT) begin
                    result_d = CANON_NAN;
                    fflags_d = FFLAGS_INVALID;
                    state_d  = RESP;
                end else begin
                    wd_d = wd_q + 8'd1;
                end
`endif
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // A clear coinciding with a handshake still keeps the newly returned flags.
    always_comb begin
        acc_d = fflags_clr ? 5'd0 : acc_q;
        if (state_q == RESP && rsp_ready) begin
            acc_d = acc_d | fflags_q;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            op_q        <= 2'd0;
            rm_q        <= 3'd0;
            opa_q       <= '0;
            opb_q       <= '0;
            signaling_q <= 1'b0;
            subsqrt_q   <= 1'b0;
            tag_q       <= '0;
            result_q    <= 32'd0;
            fflags_q    <= 5'd0;
            acc_q       <= 5'd0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            rm_q        <= rm_d;
            opa_q       <= opa_d;
            opb_q       <= opb_d;
            signaling_q <= signaling_d;
            subsqrt_q   <= subsqrt_d;
            tag_q       <= tag_d;
            result_q    <= result_d;
            fflags_q    <= fflags_d;
            acc_q       <= acc_d;
        end
    end

`ifdef FPU_MDS_WATCHDOG_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wd_q <= 8'd0;
        end else begin
            wd_q <= wd_d;
        end
    end
`endif

    assign req_ready      = (state_q == IDLE);
    assign mds_start      = (state_q == START);
    assign rsp_valid      = (state_q == RESP);
    assign mds_op         = op_q;
    assign mds_rm         = rm_q;
    assign sign_a         = opa_q.sign;
    assign exp_a          = opa_q.exp;
    assign sig_a          = opa_q.sig;
    assign is_zero_a      = opa_q.is_zero;
    assign is_inf_a       = opa_q.is_inf;
    assign is_nan_a       = opa_q.is_nan;
    assign sign_b         = opb_q.sign;
    assign exp_b          = opb_q.exp;
    assign sig_b          = opb_q.sig;
    assign is_zero_b      = opb_q.is_zero;
    assign is_inf_b       = opb_q.is_inf;
    assign is_nan_b       = opb_q.is_nan;
    assign is_signaling   = signaling_q;
    assign subnormal_sqrt = subsqrt_q;
    assign rsp_result     = result_q;
    assign rsp_tag        = tag_q;
    assign rsp_fflags     = fflags_q;
    assign fflags_acc     = acc_q;

endmodule

`default_nettype wire

// File: tb/tb_fpu_mds_issuer.sv
// ============================================================================
// tb_fpu_mds_issuer : directed self-checking bench with a simple unit model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_fpu_mds_issuer;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [1:0]  req_op = 2'd0;
    logic [2:0]  req_rm = 3'd0;
    logic [31:0] req_a = 32'd0;
    logic [31:0] req_b = 32'd0;
    logic [4:0]  req_tag = 5'd0;
    logic        mds_start;
    logic [1:0]  mds_op;
    logic [2:0]  mds_rm;
    logic        sign_a, sign_b;
    logic [7:0]  exp_a, exp_b;
    logic [23:0] sig_a, sig_b;
    logic        is_zero_a, is_zero_b, is_inf_a, is_inf_b, is_nan_a, is_nan_b;
    logic        is_signaling, subnormal_sqrt;
    logic        mds_done;
    logic [31:0] mds_out;
    logic        mds_of, mds_uf, mds_nv, mds_nx, mds_dz;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_result;
    logic [4:0]  rsp_tag;
    logic [4:0]  rsp_fflags;
    logic [4:0]  fflags_acc;
    logic        fflags_clr = 1'b0;

    int n_checks = 0;
    int n_pass   = 0;

    // Unit model: done arrives mdl_delay cycles after the start cycle.
    int          mdl_delay = 0;
    logic        mdl_en = 1'b1;
    logic [31:0] mdl_out = 32'd0;
    logic [4:0]  mdl_flags = 5'd0;
    int          mdl_cnt = 0;
    logic        mdl_pend = 1'b0;
    int          start_cnt = 0;

    assign mds_out = mdl_out;
    assign mds_nv  = mdl_flags[4];
    assign mds_dz  = mdl_flags[3];
    assign mds_of  = mdl_flags[2];
    assign mds_uf  = mdl_flags[1];
    assign mds_nx  = mdl_flags[0];

    always #5 clk = ~clk;

    fpu_mds_issuer #(.TAG_W(5), .TIMEOUT_CYCLES(64)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_rm(req_rm),
        .req_a(req_a), .req_b(req_b), .req_tag(req_tag),
        .mds_start(mds_start), .mds_op(mds_op), .mds_rm(mds_rm),
        .sign_a(sign_a), .sign_b(sign_b), .exp_a(exp_a), .exp_b(exp_b),
        .sig_a(sig_a), .sig_b(sig_b),
        .is_zero_a(is_zero_a), .is_zero_b(is_zero_b), .is_inf_a(is_inf_a), .is_inf_b(is_inf_b),
        .is_nan_a(is_nan_a), .is_nan_b(is_nan_b),
        .is_signaling(is_signaling), .subnormal_sqrt(subnormal_sqrt),
        .mds_done(mds_done), .mds_out(mds_out),
        .mds_of(mds_of), .mds_uf(mds_uf), .mds_nv(mds_nv), .mds_nx(mds_nx), .mds_dz(mds_dz),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
        .rsp_tag(rsp_tag), .rsp_fflags(rsp_fflags),
        .fflags_acc(fflags_acc), .fflags_clr(fflags_clr)
    );

    always @(negedge clk) begin
        mds_done = 1'b0;
        if (mds_start === 1'b1) begin
            start_cnt++;
            if (mdl_en) begin
                mdl_pend = 1'b1;
                mdl_cnt  = mdl_delay;
            end
        end
        if (mdl_pend) begin
            if (mdl_cnt == 0) begin
                mds_done = 1'b1;
                mdl_pend = 1'b0;
            end else begin
                mdl_cnt--;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    task automatic issue(input logic [1:0] op, input logic [2:0] rm, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] tag);
        @(negedge clk);
        req_valid = 1'b1; req_op = op; req_rm = rm; req_a = a; req_b = b; req_tag = tag;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_resp(output int cyc);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!rsp_valid && cyc < 200);
    endtask

    task automatic handshake(input logic clr);
        @(negedge clk);
        rsp_ready = 1'b1; fflags_clr = clr;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0; fflags_clr = 1'b0;
    endtask

    initial begin
        int   lat;
        int   s0;
        logic seen;

        repeat (2) @(negedge clk);
        check("rst_req_ready", req_ready, 1'b1);
        check("rst_ctl", {mds_start, rsp_valid, mds_op, mds_rm}, 0);
        check("rst_regs", {sig_a, exp_a, fflags_acc}, 0);
        check("rst_rsp", rsp_result, 32'd0);
        reset = 1'b1;

        // FMUL 2.0 x 3.0, done 3 cycles after start
        mdl_delay = 3; mdl_out = 32'h40C0_0000; mdl_flags = 5'b00000;
        start_cnt = 0;
        issue(2'b00, 3'b000, 32'h4000_0000, 32'h4040_0000, 5'd3);
        check("mul_sig_a", sig_a, 24'h800000);
        check("mul_exp_a", exp_a, 8'h80);
        check("mul_sig_b", sig_b, 24'hC00000);
        wait_resp(lat);
        check("mul_latency", lat, 5);
        check("mul_starts", start_cnt, 1);
        check("mul_result", rsp_result, 32'h40C0_0000);
        check("mul_fflags", rsp_fflags, 5'b00000);
        check("mul_tag", rsp_tag, 5'd3);
        handshake(1'b0);
        check("mul_acc", fflags_acc, 5'b00000);
        check("mul_idle", req_ready, 1'b1);

        // FDIV 1.0 / 0.0 -> inf with divide-by-zero
        mdl_delay = 1; mdl_out = 32'h7F80_0000; mdl_flags = 5'b01000;
        issue(2'b01, 3'b001, 32'h3F80_0000, 32'h0000_0000, 5'd4);
        check("div_zero_b", {is_zero_a, is_zero_b}, 2'b01);
        check("div_op_rm", {mds_op, mds_rm}, 5'b01_001);
        wait_resp(lat);
        check("div_latency", lat, 3);
        check("div_result", rsp_result, 32'h7F80_0000);
        check("div_fflags", rsp_fflags, 5'b01000);
        handshake(1'b0);
        check("div_acc", fflags_acc, 5'b01000);

        // FSQRT of smallest subnormal, B garbage must not appear
        mdl_delay = 2; mdl_out = 32'h1A35_04F3; mdl_flags = 5'b00001;
        issue(2'b10, 3'b000, 32'h0000_0001, 32'hFFFF_FFFF, 5'd12);
        check("sqrt_subnormal", subnormal_sqrt, 1'b1);
        check("sqrt_sig_a", sig_a, 24'h000001);
        check("sqrt_exp_a", exp_a, 8'h00);
        check("sqrt_b_zero", {sign_b, exp_b, sig_b, is_zero_b, is_inf_b, is_nan_b, is_signaling}, 0);
        wait_resp(lat);
        check("sqrt_latency", lat, 4);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("hold_result", rsp_result, 32'h1A35_04F3);
            check("hold_ctl", {rsp_valid, req_ready, rsp_tag, rsp_fflags}, {2'b10, 5'd12, 5'b00001});
        end
        handshake(1'b1);
        check("clr_with_hs_acc", fflags_acc, 5'b00001);

        // FMUL with signaling NaN A, fast-path done in START
        mdl_delay = 0; mdl_out = 32'h7FC0_0000; mdl_flags = 5'b10000;
        issue(2'b00, 3'b000, 32'h7F80_0001, 32'h3F80_0000, 5'd1);
        check("snan_class", {is_nan_a, is_inf_a, is_signaling}, 3'b101);
        wait_resp(lat);
        check("fast_latency", lat, 2);
        check("snan_fflags", rsp_fflags, 5'b10000);
        handshake(1'b0);
        check("snan_acc", fflags_acc, 5'b10001);

        // Illegal op: immediate canonical NaN, no start
        s0 = start_cnt;
        issue(2'b11, 3'b000, 32'h3F80_0000, 32'h3F80_0000, 5'd7);
        wait_resp(lat);
        check("ill_latency", lat, 1);
        check("ill_result", rsp_result, 32'h7FC0_0000);
        check("ill_tag", rsp_tag, 5'd7);
        check("ill_fflags", rsp_fflags, 5'b10000);
        handshake(1'b0);
        repeat (3) @(negedge clk);
        check("ill_no_start", start_cnt, s0);
        check("ill_acc", fflags_acc, 5'b10001);

        // Reset during WAIT, then a stray done arrives in IDLE
        mdl_delay = 8; mdl_out = 32'h1234_5678; mdl_flags = 5'b00100;
        issue(2'b00, 3'b000, 32'h4000_0000, 32'h4040_0000, 5'd9);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rst_mid_outs", {rsp_result, sig_a, fflags_acc, rsp_tag, rsp_valid, mds_start}, 0);
        check("rst_mid_ready", req_ready, 1'b1);
        reset = 1'b1;
        seen = 1'b0;
        repeat (12) begin
            @(negedge clk);
            seen = seen | rsp_valid | mds_start;
        end
        check("stray_done_ignored", {seen, rsp_result}, 0);
        check("stray_done_idle", req_ready, 1'b1);

`ifdef FPU_MDS_WATCHDOG_EN
        mdl_en = 1'b0;
        issue(2'b01, 3'b000, 32'h3F80_0000, 32'h4000_0000, 5'd5);
        wait_resp(lat);
        check("wd_latency", lat, 66);
        check("wd_result", rsp_result, 32'h7FC0_0000);
        check("wd_fflags", rsp_fflags, 5'b10000);
        handshake(1'b0);
        mdl_en = 1'b1;
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/fpu_mds_issuer.md
Name: fpu_mds_issuer

Overview:
- Initiator side of the FPU multiply/divide/square-root unit's start/done protocol.
- Accepts one FMUL/FDIV/FSQRT request from the FPU pipeline (valid/ready), unpacks and classifies the operands, and holds them stable for the whole operation.
- Pulses start, waits for done, captures the result and exception flags, and returns a tagged response (valid/ready).
- Also keeps the sticky accrued-fflags register for these ops.

Parameters:
TAG_W, 5, width of the request/response tag (destination register index).
TIMEOUT_CYCLES, 64, watchdog limit in WAIT; used only with FPU_MDS_WATCHDOG_EN.

Ports:
clk  input  1  clock
reset  input  1  asynchronous active-low reset
req_valid  input  1  request valid
req_ready  output  1  issuer can accept a request
req_op  input  2  00 FMUL, 01 FDIV, 10 FSQRT, 11 illegal
req_rm  input  3  rounding mode
req_a  input  32  operand A, IEEE-754 single
req_b  input  32  operand B, ignored for FSQRT
req_tag  input  TAG_W  returned unchanged with the response
mds_start  output  1  one-cycle start pulse
mds_op  output  2  registered op
mds_rm  output  3  registered rounding mode
sign_a, sign_b  output  1 each  operand signs
exp_a, exp_b  output  8 each  raw exponent fields
sig_a, sig_b  output  24 each  {hidden bit, mantissa}; hidden bit = (exp != 0)
is_zero_a, is_zero_b, is_inf_a, is_inf_b, is_nan_a, is_nan_b  output  1 each  operand classes
is_signaling  output  1  at least one counted operand is an sNaN
subnormal_sqrt  output  1  op is FSQRT and A is subnormal
mds_done  input  1  unit finished
mds_out  input  32  unit result
mds_of, mds_uf, mds_nv, mds_nx, mds_dz  input  1 each  unit exception flags
rsp_valid  output  1  response valid
rsp_ready  input  1  response accepted
rsp_result  output  32  result
rsp_tag  output  TAG_W  tag
rsp_fflags  output  5  {NV,DZ,OF,UF,NX} for this op
fflags_acc  output  5  sticky OR of all returned rsp_fflags
fflags_clr  input  1  clear fflags_acc

Behaviour:
- Reset: state IDLE. All outputs 0 except req_ready=1. This includes fflags_acc and all operand registers.
- Classification is registered at accept:
  - zero = exp==00 && man==0
  - inf = exp==FF && man==0
  - nan = exp==FF && man!=0
  - sNaN = nan && man[22]==0
- FSQRT: all B outputs are forced to 0; is_signaling counts A only; subnormal_sqrt = exp_a==0 && man_a!=0.
- Operand outputs stay constant from accept until return to IDLE.
- IDLE:
  - req_ready=1.
  - req_valid with op != 11: capture the request, go START.
  - req_valid with op == 11: capture tag, rsp_result=7FC00000, rsp_fflags=10000, go RESP. No start is issued.
- START: mds_start=1 for exactly this cycle; go WAIT. mds_done is sampled here as well as in WAIT, so a fast-path done in this cycle is captured.
- WAIT: on mds_done, rsp_result<=mds_out and rsp_fflags<={nv,dz,of,uf,nx}; go RESP.
- RESP:
  - rsp_valid=1; result, tag and fflags hold stable while rsp_ready=0.
  - On rsp_ready, go IDLE. The next request is accepted no earlier than the following cycle, so there is no same-cycle turnaround.
- Minimum latency from accept to rsp_valid: 2 cycles with done in START, otherwise 3 or more.
- fflags_acc:
  - Updated on the response handshake: acc <= (fflags_clr ? 0 : acc) | rsp_fflags.
  - A clear that coincides with a handshake keeps the new flags.
- mds_done outside START/WAIT is ignored.
- Reset asserted mid-operation returns to IDLE immediately and drops any in-flight result. The unit shares the reset.

Optional Feature:
FPU_MDS_WATCHDOG_EN.
- Defined:
  - An 8-bit counter clears on entry to WAIT and increments each WAIT cycle.
  - When it reaches TIMEOUT_CYCLES without done: rsp_result=7FC00000, rsp_fflags=10000, go RESP.
  - A later stray done is ignored.
- Undefined: no counter; WAIT lasts until done.

Decomposition:
- Package fpu_mds_pkg holds:
  - op codes MDS_MUL/MDS_DIV/MDS_SQRT/MDS_ILL
  - state enum IDLE/START/WAIT/RESP
  - CANON_NAN = 32'h7FC00000
  - fflags bit indices NV=4, DZ=3, OF=2, UF=1, NX=0
- Sub-module fpu_operand_classify (combinational): 32-bit operand in; sign, exp, sig, zero/inf/nan/snan/subnormal out. Instantiated twice.

Test Plan:
- FMUL 40000000 x 40400000, rm=000; model sets done 3 cycles after start with out 40C00000 -> single mds_start pulse, sig_a=800000, rsp_result=40C00000, rsp_fflags=00000.
- FDIV 3F800000 / 00000000; model returns 7F800000 with dz -> is_zero_b=1, rsp_fflags=01000, fflags_acc=01000.
- FSQRT 00000001 with req_b=FFFFFFFF -> subnormal_sqrt=1, sig_a=000001, exp_a=00, all B outputs 0.
- Hold rsp_ready=0 for 5 cycles in RESP -> result/tag stable, req_ready=0; fflags_clr with simultaneous handshake -> acc equals new flags only.
- req_op=11 with tag 7 -> no mds_start, response 7FC00000, tag 7, fflags 10000.
- Reset pulsed in WAIT, then a stray done -> outputs zero, state IDLE, no response. With FPU_MDS_WATCHDOG_EN and no done -> timeout response after 64 WAIT cycles.
